keypad_entry: RTL and testbench

Upstream input stage for the credential-check control unit. Scans a 4x4 active-low matrix keypad, debounces key presses and releases, and presents the accepted key as a held 4-bit code on `ubInputData`. The control unit compares `ubInputData` against the stored credential. A one-cycle strobe and a held level are also provided for counting and display logic.

---
 rtl/keypad_entry_if.sv | 40 ++++
 rtl/keypad_entry.sv | 194 +++++++++++++++++++
 tb/tb_keypad_entry.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// ============================================================================
// Module      : keypad_entry_if
// Description : Signal bundle between the keypad input stage and its
//               environment (keypad matrix and the credential-check logic).
//               The slave modport is the keypad_entry side; the master
//               modport is the keypad/consumer side.
// Ports       : iRows        - keypad rows, active-low (into keypad_entry)
//               oCols        - column drive, one-hot-low
//               ubInputData  - last accepted key code (held)
//               vfnKeyStrobe - one-cycle pulse on key acceptance
//               vfnKeyHeld   - high from acceptance until release debounced
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_entry_if;
   logic [3:0] iRows;
   logic [3:0] oCols;
   logic [3:0] ubInputData;
   logic       vfnKeyStrobe;
   logic       vfnKeyHeld;

   modport master (
      output iRows,
      input  oCols,
      input  ubInputData,
      input  vfnKeyStrobe,
      input  vfnKeyHeld
   );

   modport slave (
      input  iRows,
      output oCols,
      output ubInputData,
      output vfnKeyStrobe,
      output vfnKeyHeld
   );
endinterface

`default_nettype wire

// File: rtl/keypad_entry.sv
// ============================================================================
// Module      : keypad_entry
// Description : 4x4 active-low matrix keypad scanner with press and release
//               debouncing. Presents the accepted key as a held 4-bit code
//               (4*row + column), plus a one-cycle strobe and a held level.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               kp   - keypad_entry_if.slave (iRows in; oCols, ubInputData,
//                      vfnKeyStrobe, vfnKeyHeld out; all outputs registered)
// Parameters  : SCAN_DIV   - cycles each column is driven (>= 4)
//               DEB_CYCLES - stable cycles to accept a press / release (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry #(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CYCLES = 20000
) (
   input  logic         clk,
   input  logic         rst,
   keypad_entry_if.slave kp
);

   // One counter serves both the scan divider and the debounce timer.
   localparam int CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SCAN_TC = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [3:0]       ROWS_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       sync1_q;
   logic [3:0]       rs_q;
   logic [3:0]       cols_q, cols_d;
   logic [3:0]       pat_q, pat_d;
   logic [3:0]       code_q, code_d;
   logic [3:0]       data_q, data_d;
   logic             strobe_q, strobe_d;
   logic             held_q, held_d;

   logic [2:0]       low_cnt;
   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic [3:0]       cols_rot;

   // ------------------------------------------------------------------
   // Row synchronizer: idle value (all high) so reset never looks like a key
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= ROWS_IDLE;
         rs_q    <= ROWS_IDLE;
      end else begin
         sync1_q <= kp.iRows;
         rs_q    <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Row/column decode. low_cnt lets the scanner reject multi-key chords.
   // ------------------------------------------------------------------
   always_comb begin
      low_cnt = 3'd0;
      row_idx = 2'd0;
      col_idx = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!rs_q[r]) begin
            low_cnt = low_cnt + 3'd1;
            row_idx = 2'(r);
         end
      end
      for (int c = 0; c < 4; c++) begin
         if (!cols_q[c]) begin
            col_idx = 2'(c);
         end
      end
   end

   // Rotating the single low bit left walks col0 -> col1 -> col2 -> col3 -> col0.
   assign cols_rot = {cols_q[2:0], cols_q[3]};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SCAN;
         cnt_q    <= '0;
         cols_q   <= 4'b1110;
         pat_q    <= ROWS_IDLE;
         code_q   <= 4'd0;
         data_q   <= 4'd0;
         strobe_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cols_q   <= cols_d;
         pat_q    <= pat_d;
         code_q   <= code_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         held_q   <= held_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      cols_d   = cols_q;
      pat_d    = pat_q;
      code_d   = code_q;
      data_d   = data_q;
      strobe_d = 1'b0;
      held_d   = held_q;

      case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_TC) begin
               cnt_d = '0;
               if (low_cnt == 3'd1) begin
                  // Keep the column driven so the debounce watches the same key.
                  pat_d   = rs_q;
                  code_d  = {row_idx, col_idx};
                  state_d = ST_DEBOUNCE;
               end else begin
                  cols_d = cols_rot;
               end
            end
         end

         ST_DEBOUNCE: begin
            // Mismatch is tested before the terminal count, so a row change
            // on the last cycle rejects the key.
            if (rs_q != pat_q) begin
               cnt_d   = '0;
               cols_d  = cols_rot;
               state_d = ST_SCAN;
            end else if (cnt_q == DEB_TC) begin
               cnt_d    = '0;
               data_d   = code_q;
               strobe_d = 1'b1;
               held_d   = 1'b1;
               state_d  = ST_HELD;
            end
         end

         ST_HELD: begin
            // Counter parked at zero; no auto-repeat from here.
            cnt_d = '0;
            if (rs_q == ROWS_IDLE) begin
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (rs_q != ROWS_IDLE) begin
               cnt_d   = '0;
               state_d = ST_HELD;
            end else if (cnt_q == DEB_TC) begin
               cnt_d   = '0;
               held_d  = 1'b0;
               cols_d  = cols_rot;
               state_d = ST_SCAN;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_SCAN;
         end
      endcase
   end

   assign kp.oCols        = cols_q;
   assign kp.ubInputData  = data_q;
   assign kp.vfnKeyStrobe = strobe_q;
   assign kp.vfnKeyHeld   = held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ============================================================================
// Module      : tb_keypad_entry
// Description : Self-checking bench for keypad_entry with a behavioural
//               keypad matrix model and an expected-code scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] keys = 16'h0000;   // bit r*4+c = key (r,c) pressed

   int checks = 0;
   int errors = 0;
   int nstrobe = 0;
   logic [3:0] sb[$];

   keypad_entry_if kp_if ();

   keypad_entry #(
      .SCAN_DIV   (4),
      .DEB_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp_if)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a row is pulled low only through a pressed key whose
   // column is currently driven low.
   logic [3:0] rows_m;
   always_comb begin
      rows_m = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !kp_if.oCols[c]) begin
               rows_m[r] = 1'b0;
            end
         end
      end
   end
   assign kp_if.iRows = rows_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest expected code.
   always @(negedge clk) begin
      if (rst === 1'b0 && kp_if.vfnKeyStrobe === 1'b1) begin
         nstrobe++;
         chk("strobe_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            chk("strobe_code", 32'(kp_if.ubInputData), 32'(sb.pop_front()));
         end
      end
   end

   task automatic wait_strobe(input string tag);
      int n = 0;
      while (kp_if.vfnKeyStrobe !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(kp_if.vfnKeyStrobe), 32'd1);
   endtask

   task automatic wait_held_low(input string tag);
      int n = 0;
      while (kp_if.vfnKeyHeld !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(kp_if.vfnKeyHeld), 32'd0);
   endtask

   initial begin
      logic [3:0] exp_cols;
      logic [3:0] prev_cols;
      int n0;
      int changes;
      int n;
      logic held_ok;

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      chk("rst_cols",   32'(kp_if.oCols),        32'hE);
      chk("rst_data",   32'(kp_if.ubInputData),  32'h0);
      chk("rst_strobe", 32'(kp_if.vfnKeyStrobe), 32'h0);
      chk("rst_held",   32'(kp_if.vfnKeyHeld),   32'h0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge clk);
         exp_cols = ~(4'b0001 << (i / 4));
         chk("rotate", 32'(kp_if.oCols), 32'(exp_cols));
      end

      // ---------------- clean press (2,1) ----------------
      n0 = nstrobe;
      sb.push_back(4'd9);
      keys = 16'h0001 << (2*4+1);
      wait_strobe("clean_strobe");
      chk("clean_data", 32'(kp_if.ubInputData), 32'd9);
      chk("clean_held", 32'(kp_if.vfnKeyHeld),  32'd1);
      @(negedge clk);
      chk("clean_strobe_width", 32'(kp_if.vfnKeyStrobe), 32'd0);
      repeat (100) @(negedge clk);
      chk("clean_held_long", 32'(kp_if.vfnKeyHeld), 32'd1);
      keys = 16'h0000;
      repeat (10) @(negedge clk);
      chk("clean_held_before_rel", 32'(kp_if.vfnKeyHeld), 32'd1);
      @(negedge clk);
      chk("clean_held_released", 32'(kp_if.vfnKeyHeld), 32'd0);
      chk("clean_resume_col",    32'(kp_if.oCols),      32'hB);
      chk("clean_one_strobe",    32'(nstrobe - n0),     32'd1);

      // ---------------- bouncy press (0,3) ----------------
      n0 = nstrobe;
      for (int i = 0; i < 10; i++) begin
         keys[3] = ~keys[3];
         repeat (3) @(negedge clk);
      end
      chk("bounce_no_strobe", 32'(nstrobe - n0), 32'd0);
      sb.push_back(4'd3);
      keys = 16'h0001 << 3;
      wait_strobe("bounce_strobe");
      chk("bounce_data", 32'(kp_if.ubInputData), 32'd3);
      repeat (20) @(negedge clk);
      keys = 16'h0000;
      wait_held_low("bounce_release");
      chk("bounce_one_strobe", 32'(nstrobe - n0), 32'd1);

      // ---------------- multi-key (0,0)+(1,0) ----------------
      n0 = nstrobe;
      keys = (16'h0001 << 0) | (16'h0001 << 4);
      changes = 0;
      prev_cols = kp_if.oCols;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (kp_if.oCols != prev_cols) changes++;
         prev_cols = kp_if.oCols;
      end
      chk("multi_no_strobe", 32'(nstrobe - n0),        32'd0);
      chk("multi_rotations", 32'(changes),             32'd16);
      chk("multi_data_kept", 32'(kp_if.ubInputData),   32'd3);
      chk("multi_held",      32'(kp_if.vfnKeyHeld),    32'd0);
      keys = 16'h0000;
      repeat (8) @(negedge clk);

      // ---------------- long hold with release glitch (3,3) ----------------
      n0 = nstrobe;
      sb.push_back(4'd15);
      keys = 16'h0001 << 15;
      wait_strobe("long_strobe");
      held_ok = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         held_ok = held_ok & kp_if.vfnKeyHeld;
      end
      keys = 16'h0000;
      repeat (5) begin
         @(negedge clk);
         held_ok = held_ok & kp_if.vfnKeyHeld;
      end
      keys = 16'h0001 << 15;
      repeat (50) begin
         @(negedge clk);
         held_ok = held_ok & kp_if.vfnKeyHeld;
      end
      chk("long_held_throughout", 32'(held_ok),            32'd1);
      chk("long_data",            32'(kp_if.ubInputData),  32'd15);
      chk("long_one_strobe",      32'(nstrobe - n0),       32'd1);
      keys = 16'h0000;
      wait_held_low("long_release");

      // ---------------- reset mid-operation (1,2) ----------------
      n0 = nstrobe;
      keys = 16'h0001 << (1*4+2);
      n = 0;
      while (kp_if.oCols == 4'b1011 && n < 100) begin @(negedge clk); n++; end
      while (kp_if.oCols != 4'b1011 && n < 100) begin @(negedge clk); n++; end
      chk("mid_found_col2", 32'(kp_if.oCols), 32'hB);
      repeat (7) @(negedge clk);
      chk("mid_in_debounce", 32'(kp_if.oCols), 32'hB);
      rst = 1'b1;
      #1;
      chk("mid_rst_cols",   32'(kp_if.oCols),        32'hE);
      chk("mid_rst_data",   32'(kp_if.ubInputData),  32'h0);
      chk("mid_rst_strobe", 32'(kp_if.vfnKeyStrobe), 32'h0);
      chk("mid_rst_held",   32'(kp_if.vfnKeyHeld),   32'h0);
      repeat (3) @(negedge clk);
      chk("mid_no_strobe", 32'(nstrobe - n0), 32'd0);
      sb.push_back(4'd6);
      rst = 1'b0;
      wait_strobe("mid_strobe");
      chk("mid_data", 32'(kp_if.ubInputData), 32'd6);
      keys = 16'h0000;
      wait_held_low("mid_release");

      repeat (4) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
